uart_tx_param: RTL and testbench



---
 rtl/uart_tx_param.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// UART transmitter: FIFO-buffered, runtime parity/stop-bit selection, registered glitch-free line.
// Frame config is captured at the pop so mid-frame input changes only affect later frames.
`timescale 1ns/1ps
module uart_tx_param #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [1:0]        parity_mode,
   input  logic              stop2,
   output logic              full,
   output logic              empty,
   output logic              busy,
   output logic              overflow,
   output logic              tx_done,
   output logic              tx
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_W);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
   logic [PW-1:0]     wptr_q, rptr_q;
   logic [PW:0]       cnt_q, cnt_d;
   logic              full_q, empty_q, ovf_q;
   logic              push, pop, load;

   state_t            state_q, state_d;
   logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [DATA_W-1:0] shift_q, shift_d, head;
   logic              parbit_q, parbit_d;
   logic [1:0]        pmode_q, pmode_d;
   logic              stop2_q, stop2_d;
   logic              tx_q, tx_d, busy_q, done_q, done_d;
   logic              bit_end, has_par;

   assign push    = wr_en & ~full_q;
   assign head    = fifo_q[rptr_q];
   assign bit_end = (bit_cnt_q == BIT_LAST);
   assign has_par = (pmode_q == 2'd1) || (pmode_q == 2'd2);

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + (PW+1)'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - (PW+1)'(1);
      end
   end

   // A write while full is dropped even if a pop frees a slot in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + PW'(1);
         if (pop)  rptr_q <= rptr_q + PW'(1);
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == CNT_FULL);
         empty_q <= (cnt_d == '0);
         ovf_q   <= wr_en & full_q;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wptr_q] <= wr_data;
      shift_q  <= shift_d;
      parbit_q <= parbit_d;
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      parbit_d  = parbit_q;
      pmode_d   = pmode_q;
      stop2_d   = stop2_q;
      load      = 1'b0;
      pop       = 1'b0;
      case (state_q)
         IDLE: load = ~empty_q;
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               bit_cnt_d = '0;
               idx_d     = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               bit_cnt_d = '0;
               shift_d   = shift_q >> 1;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = has_par ? PARITY : STOP;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d   = STOP;
               bit_cnt_d = '0;
               idx_d     = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               bit_cnt_d = '0;
               if (idx_q == {{(IW-1){1'b0}}, stop2_q}) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  load    = ~empty_q;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // Pop path is shared by IDLE and the last stop cycle, giving zero-gap back-to-back frames.
      if (load) begin
         pop       = 1'b1;
         shift_d   = head;
         parbit_d  = (^head) ^ (parity_mode == 2'd2);
         pmode_d   = parity_mode;
         stop2_d   = stop2;
         state_d   = START;
         bit_cnt_d = '0;
         idx_d     = '0;
      end
   end

   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = parbit_d;
         default: tx_d = 1'b1;
      endcase
      done_d = (state_d == STOP) && (bit_cnt_d == BIT_LAST) &&
               (idx_d == {{(IW-1){1'b0}}, stop2_d});
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         idx_q     <= '0;
         pmode_q   <= 2'd0;
         stop2_q   <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         idx_q     <= idx_d;
         pmode_q   <= pmode_d;
         stop2_q   <= stop2_d;
         tx_q      <= tx_d;
         busy_q    <= (state_d != IDLE);
         done_q    <= done_d;
      end
   end

   assign full     = full_q;
   assign empty    = empty_q;
   assign overflow = ovf_q;
   assign busy     = busy_q;
   assign tx_done  = done_q;
   assign tx       = tx_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: a default-parameter instance and a fast (4 clk/bit) instance.
`timescale 1ns/1ps
module tb_uart_tx_param;
   localparam int B_CPB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_wr_en, a_stop2, b_wr_en, b_stop2;
   logic [7:0] a_wr_data, b_wr_data;
   logic [1:0] a_pm, b_pm;
   logic       a_full, a_empty, a_busy, a_ovf, a_done, a_tx;
   logic       b_full, b_empty, b_busy, b_ovf, b_done, b_tx;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         b_ovf_cnt = 0;

   always #5 clk = ~clk;

   uart_tx_param u_a (
      .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_data(a_wr_data),
      .parity_mode(a_pm), .stop2(a_stop2), .full(a_full), .empty(a_empty),
      .busy(a_busy), .overflow(a_ovf), .tx_done(a_done), .tx(a_tx)
   );

   uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(B_CPB), .FIFO_DEPTH(4)) u_b (
      .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_data(b_wr_data),
      .parity_mode(b_pm), .stop2(b_stop2), .full(b_full), .empty(b_empty),
      .busy(b_busy), .overflow(b_ovf), .tx_done(b_done), .tx(b_tx)
   );

   always @(negedge clk) if (b_ovf === 1'b1) b_ovf_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic b_write_one(input logic [7:0] d);
      @(posedge clk); #1;
      b_wr_en = 1'b1; b_wr_data = d;
      @(posedge clk); #1;
      b_wr_en = 1'b0;
   endtask

   // bits[i] is the expected level of frame bit i (bit 0 = start).
   task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits,
                              output int gap);
      int donepos = -1;
      int ndone = 0;
      gap = 0;
      @(negedge clk);
      while (b_tx !== 1'b0 && gap < 100) begin
         gap++;
         @(negedge clk);
      end
      if (b_tx !== 1'b0) begin
         chk({tag, "_start"}, b_tx, 0);
         return;
      end
      for (int c = 0; c < nbits*B_CPB; c++) begin
         if (c > 0) @(negedge clk);
         if (c % B_CPB == B_CPB/2) chk($sformatf("%s_bit%0d", tag, c/B_CPB), b_tx, bits[c/B_CPB]);
         if (b_done === 1'b1) begin
            ndone++;
            if (donepos < 0) donepos = c;
         end
      end
      chk({tag, "_done_pos"}, donepos, nbits*B_CPB - 1);
      chk({tag, "_done_cnt"}, ndone, 1);
   endtask

   initial begin
      int bad, donepos, ndone, g;
      logic [15:0] a_exp;
      logic [7:0]  vals [6];
      logic [15:0] fexp [5];

      rst = 1'b0;
      a_wr_en = 0; a_wr_data = 0; a_pm = 0; a_stop2 = 0;
      b_wr_en = 0; b_wr_data = 0; b_pm = 0; b_stop2 = 0;
      repeat (3) @(negedge clk);
      chk("rst_tx", a_tx, 1);
      chk("rst_empty", a_empty, 1);
      chk("rst_busy", a_busy, 0);
      chk("rst_full", a_full, 0);
      chk("rst_pulses", {a_done, a_ovf}, 0);
      rst = 1'b1;

      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (a_tx !== 1'b1 || a_empty !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0 ||
             a_ovf !== 1'b0 || b_tx !== 1'b1 || b_busy !== 1'b0) bad++;
      end
      chk("idle_100", bad, 0);

      // default instance: even parity, one stop bit, 0x0C
      a_pm = 2'd1; a_stop2 = 1'b0;
      a_exp = 16'h0418;
      @(posedge clk); #1;
      a_wr_en = 1'b1; a_wr_data = 8'h0C;
      @(posedge clk); #1;
      a_wr_en = 1'b0;
      chk("a_empty_after_wr", a_empty, 0);
      chk("a_tx_before_pop", a_tx, 1);
      @(posedge clk); #1;
      chk("a_tx_start", a_tx, 0);
      chk("a_busy_start", a_busy, 1);
      chk("a_empty_after_pop", a_empty, 1);
      donepos = -1; ndone = 0;
      for (int c = 0; c < 4774; c++) begin
         @(negedge clk);
         if (c % 434 == 217) chk($sformatf("a_bit%0d", c/434), a_tx, a_exp[c/434]);
         if (a_done === 1'b1) begin
            ndone++;
            if (donepos < 0) donepos = c;
         end
      end
      chk("a_done_pos", donepos, 4773);
      chk("a_done_cnt", ndone, 1);
      @(negedge clk);
      chk("a_tx_after", a_tx, 1);
      chk("a_busy_after", a_busy, 0);

      // fast instance: odd parity, two stop bits, 0x55
      b_pm = 2'd2; b_stop2 = 1'b1;
      fork
         b_write_one(8'h55);
         check_frame("odd55", 16'h0EAA, 12, g);
      join
      @(negedge clk);
      chk("odd55_tx_after", b_tx, 1);
      chk("odd55_busy_after", b_busy, 0);

      // FIFO fill, one pop during the burst, then a dropped sixth write
      b_pm = 2'd0; b_stop2 = 1'b0;
      vals = '{8'hAA, 8'h08, 8'h0C, 8'hFF, 8'h11, 8'h77};
      fexp = '{16'h0354, 16'h0210, 16'h0218, 16'h03FE, 16'h0222};
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               @(posedge clk); #1;
               if (i == 5) begin
                  chk("fifo_full", b_full, 1);
                  chk("fifo_no_ovf", b_ovf_cnt, 0);
               end
               b_wr_en = 1'b1; b_wr_data = vals[i];
            end
            @(posedge clk); #1;
            b_wr_en = 1'b0;
            repeat (2) @(negedge clk);
            chk("fifo_ovf_once", b_ovf_cnt, 1);
         end
         begin
            for (int i = 0; i < 5; i++) begin
               check_frame($sformatf("burst%0d", i), fexp[i], 10, g);
               if (i > 0) chk($sformatf("burst%0d_gap", i), g, 0);
            end
         end
      join
      @(negedge clk);
      chk("burst_tx_after", b_tx, 1);
      chk("burst_busy_after", b_busy, 0);
      chk("burst_empty_after", b_empty, 1);
      chk("burst_ovf_total", b_ovf_cnt, 1);

      // parity change mid-frame applies only to the next frame
      fork
         begin
            b_write_one(8'h0C);
            repeat (8) @(posedge clk);
            #1 b_pm = 2'd1;
            b_write_one(8'h08);
         end
         begin
            check_frame("np0c", 16'h0218, 10, g);
            check_frame("ev08", 16'h0610, 11, g);
            chk("ev08_gap", g, 0);
         end
      join
      b_pm = 2'd0;
      repeat (2) @(negedge clk);

      // reset during DATA with two entries queued
      @(posedge clk); #1;
      b_wr_en = 1'b1; b_wr_data = 8'h00;
      @(posedge clk); #1;
      b_wr_data = 8'h34;
      @(posedge clk); #1;
      b_wr_data = 8'h56;
      @(posedge clk); #1;
      b_wr_en = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("pre_rst_busy", b_busy, 1);
      chk("pre_rst_tx", b_tx, 0);
      chk("pre_rst_empty", b_empty, 0);
      rst = 1'b0;
      #1;
      chk("rst_mid_tx", b_tx, 1);
      chk("rst_mid_empty", b_empty, 1);
      chk("rst_mid_busy", b_busy, 0);
      chk("rst_mid_full", b_full, 0);
      @(negedge clk);
      rst = 1'b1;
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (b_tx !== 1'b1 || b_busy !== 1'b0 || b_empty !== 1'b1 || b_done !== 1'b0) bad++;
      end
      chk("post_rst_quiet", bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
